// File: rtl/spi_master_if.sv
// spi_master_if: request/response bundle between the core-side bus adapter
// and the SPI master.
//   req_valid/req_ready   : request handshake
//   req_len/req_tx        : bit count and right-aligned transmit word
//   req_lsb_first         : bit order of the transaction
//   resp_valid/resp_rx    : one-cycle response strobe and received word
//   busy                  : transaction in progress
// Modport master is the requester side, modport slave is the SPI master block.
interface spi_master_if #(
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               req_valid;
    logic               req_ready;
    logic [LW-1:0]      req_len;
    logic [MAX_LEN-1:0] req_tx;
    logic               req_lsb_first;
    logic               resp_valid;
    logic [MAX_LEN-1:0] resp_rx;
    logic               busy;

    modport master (
        output req_valid, req_len, req_tx, req_lsb_first,
        input  req_ready, resp_valid, resp_rx, busy
    );

    modport slave (
        input  req_valid, req_len, req_tx, req_lsb_first,
        output req_ready, resp_valid, resp_rx, busy
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: mode-0 (CPOL=0) SPI master for 1..MAX_LEN bit transactions.
// Ports:
//   clk, reset  : system clock, asynchronous active-high reset
//   bus         : spi_master_if.slave request/response bundle
//   sck, ss     : SPI clock (idles low), active-low slave select
//   mosi        : serial out (idles high)
//   miso        : serial in, already synchronous to clk
// Parameters: DIV = sck half-period in clk cycles (>=1), MAX_LEN = word width.
// Every output comes straight from a flop.
module spi_master #(
    parameter int DIV     = 4,
    parameter int MAX_LEN = 16
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.slave  bus,
    output logic         sck,
    output logic         ss,
    output logic         mosi,
    input  logic         miso
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Transmit bit for sample index k. MSB-first index is len-1-k; the IW-bit
    // wrap makes len==MAX_LEN (low bits zero) come out as MAX_LEN-1-k.
    function automatic logic pick_bit(input logic [MAX_LEN-1:0] tx,
                                      input logic [IW-1:0]      k,
                                      input logic [IW-1:0]      len,
                                      input logic               lsb);
        logic [IW-1:0] idx;
        idx = lsb ? k : (len - k - IW'(1));
        return tx[idx];
    endfunction

    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic [LW-1:0]      bit_cnt_r, bit_cnt_s, bit_nxt_s;
    logic [LW-1:0]      len_r, len_s, eff_len_s;
    logic [MAX_LEN-1:0] tx_r, tx_s;
    logic               lsb_r, lsb_s;
    logic [MAX_LEN-1:0] rx_r, rx_s;
    logic               sck_r, sck_s;
    logic               ss_r, ss_s;
    logic               mosi_r, mosi_s;
    logic               resp_valid_r, resp_valid_s;
    logic [MAX_LEN-1:0] resp_rx_r, resp_rx_s;
    logic               busy_r, busy_s;
    logic               ready_r, ready_s;
    logic               tick_s;

    // Length of 0 or beyond MAX_LEN means a full-width transaction.
    always_comb begin
        if ((bus.req_len == LW'(0)) || (bus.req_len > LW'(MAX_LEN))) begin
            eff_len_s = LW'(MAX_LEN);
        end else begin
            eff_len_s = bus.req_len;
        end
    end

    // Half-period divider wrap and the bit count after the current bit.
    always_comb begin
        tick_s    = (cnt_r == CW'(DIV - 1));
        bit_nxt_s = bit_cnt_r + LW'(1);
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        bit_cnt_s    = bit_cnt_r;
        len_s        = len_r;
        tx_s         = tx_r;
        lsb_s        = lsb_r;
        rx_s         = rx_r;
        sck_s        = sck_r;
        ss_s         = ss_r;
        mosi_s       = mosi_r;
        resp_valid_s = 1'b0;
        resp_rx_s    = resp_rx_r;
        busy_s       = busy_r;
        ready_s      = ready_r;

        case (state_r)
            ST_IDLE: begin
                busy_s  = 1'b0;
                ready_s = 1'b1;
                ss_s    = 1'b1;
                sck_s   = 1'b0;
                mosi_s  = 1'b1;
                // ready_r is low in the response cycle, so no accept there.
                if (bus.req_valid && ready_r) begin
                    state_s   = ST_SETUP;
                    len_s     = eff_len_s;
                    tx_s      = bus.req_tx;
                    lsb_s     = bus.req_lsb_first;
                    rx_s      = {MAX_LEN{1'b0}};
                    cnt_s     = {CW{1'b0}};
                    bit_cnt_s = {LW{1'b0}};
                    ss_s      = 1'b0;
                    mosi_s    = pick_bit(bus.req_tx, {IW{1'b0}},
                                         eff_len_s[IW-1:0], bus.req_lsb_first);
                    busy_s    = 1'b1;
                    ready_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // The wrap that ends setup is also the first rising sck edge.
                if (tick_s) begin
                    cnt_s   = {CW{1'b0}};
                    sck_s   = 1'b1;
                    state_s = ST_XFER;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_XFER: begin
                if (tick_s) begin
                    cnt_s = {CW{1'b0}};
                    sck_s = ~sck_r;
                    if (sck_r) begin
                        // Falling edge: capture miso, then advance the bit.
                        if (lsb_r) begin
                            rx_s[bit_cnt_r[IW-1:0]] = miso;
                        end else begin
                            rx_s = {rx_r[MAX_LEN-2:0], miso};
                        end
                        bit_cnt_s = bit_nxt_s;
                        if (bit_nxt_s == len_r) begin
                            state_s = ST_HOLD;
                        end else begin
                            mosi_s = pick_bit(tx_r, bit_nxt_s[IW-1:0],
                                              len_r[IW-1:0], lsb_r);
                        end
                    end else begin
                        mosi_s = mosi_r;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_HOLD: begin
                if (tick_s) begin
                    cnt_s        = {CW{1'b0}};
                    bit_cnt_s    = {LW{1'b0}};
                    ss_s         = 1'b1;
                    mosi_s       = 1'b1;
                    resp_valid_s = 1'b1;
                    resp_rx_s    = rx_r;
                    busy_s       = 1'b0;
                    ready_s      = 1'b0;
                    state_s      = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                ss_s    = 1'b1;
                sck_s   = 1'b0;
                mosi_s  = 1'b1;
                busy_s  = 1'b0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces the idle pin levels at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CW{1'b0}};
            bit_cnt_r    <= {LW{1'b0}};
            len_r        <= {LW{1'b0}};
            tx_r         <= {MAX_LEN{1'b0}};
            lsb_r        <= 1'b0;
            rx_r         <= {MAX_LEN{1'b0}};
            sck_r        <= 1'b0;
            ss_r         <= 1'b1;
            mosi_r       <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rx_r    <= {MAX_LEN{1'b0}};
            busy_r       <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            len_r        <= len_s;
            tx_r         <= tx_s;
            lsb_r        <= lsb_s;
            rx_r         <= rx_s;
            sck_r        <= sck_s;
            ss_r         <= ss_s;
            mosi_r       <= mosi_s;
            resp_valid_r <= resp_valid_s;
            resp_rx_r    <= resp_rx_s;
            busy_r       <= busy_s;
            ready_r      <= ready_s;
        end
    end

    assign sck            = sck_r;
    assign ss             = ss_r;
    assign mosi           = mosi_r;
    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rx    = resp_rx_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master. Three instances (DIV=4, 2, 1)
// share clk, reset and miso; sel picks the one being driven and observed.
module tb_spi_master;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic        req_valid_tb;
    logic [4:0]  req_len_tb;
    logic [15:0] req_tx_tb;
    logic        req_lsb_tb;
    logic [1:0]  miso_mode;
    logic        miso_const;
    logic        miso;
    logic [2:0]  sck_a, ss_a, mosi_a;
    logic        sck_m, ss_m, mosi_m, rv_m, rdy_m, busy_m;
    logic [15:0] rx_m;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_master_if #(.MAX_LEN(16)) if_d4 ();
    spi_master_if #(.MAX_LEN(16)) if_d2 ();
    spi_master_if #(.MAX_LEN(16)) if_d1 ();

    assign if_d4.req_valid     = req_valid_tb && (sel == 2'd0);
    assign if_d4.req_len       = req_len_tb;
    assign if_d4.req_tx        = req_tx_tb;
    assign if_d4.req_lsb_first = req_lsb_tb;
    assign if_d2.req_valid     = req_valid_tb && (sel == 2'd1);
    assign if_d2.req_len       = req_len_tb;
    assign if_d2.req_tx        = req_tx_tb;
    assign if_d2.req_lsb_first = req_lsb_tb;
    assign if_d1.req_valid     = req_valid_tb && (sel == 2'd2);
    assign if_d1.req_len       = req_len_tb;
    assign if_d1.req_tx        = req_tx_tb;
    assign if_d1.req_lsb_first = req_lsb_tb;

    spi_master #(.DIV(4), .MAX_LEN(16)) u_dut_d4 (
        .clk(clk), .reset(reset), .bus(if_d4),
        .sck(sck_a[0]), .ss(ss_a[0]), .mosi(mosi_a[0]), .miso(miso));
    spi_master #(.DIV(2), .MAX_LEN(16)) u_dut_d2 (
        .clk(clk), .reset(reset), .bus(if_d2),
        .sck(sck_a[1]), .ss(ss_a[1]), .mosi(mosi_a[1]), .miso(miso));
    spi_master #(.DIV(1), .MAX_LEN(16)) u_dut_d1 (
        .clk(clk), .reset(reset), .bus(if_d1),
        .sck(sck_a[2]), .ss(ss_a[2]), .mosi(mosi_a[2]), .miso(miso));

    // Route the selected instance to the observation signals.
    always_comb begin
        sck_m = sck_a[2]; ss_m = ss_a[2]; mosi_m = mosi_a[2];
        rv_m = if_d1.resp_valid; rdy_m = if_d1.req_ready;
        busy_m = if_d1.busy; rx_m = if_d1.resp_rx;
        case (sel)
            2'd0: begin
                sck_m = sck_a[0]; ss_m = ss_a[0]; mosi_m = mosi_a[0];
                rv_m = if_d4.resp_valid; rdy_m = if_d4.req_ready;
                busy_m = if_d4.busy; rx_m = if_d4.resp_rx;
            end
            2'd1: begin
                sck_m = sck_a[1]; ss_m = ss_a[1]; mosi_m = mosi_a[1];
                rv_m = if_d2.resp_valid; rdy_m = if_d2.req_ready;
                busy_m = if_d2.busy; rx_m = if_d2.resp_rx;
            end
            default: begin
                sck_m = sck_a[2];
            end
        endcase
    end

    // Bitrev slave: samples mosi on rise for 8 bits driving 1, then returns
    // the received byte MSB-first, updating miso on each rise.
    int         slv_cnt  = 0;
    logic [7:0] slv_sh   = 8'h00;
    logic       slv_miso = 1'b1;
    always @(posedge sck_m or posedge ss_m) begin
        if (ss_m) begin
            slv_cnt  = 0;
            slv_miso = 1'b1;
        end else begin
            slv_cnt = slv_cnt + 1;
            if (slv_cnt <= 8) begin
                slv_sh   = {slv_sh[6:0], mosi_m};
                slv_miso = 1'b1;
            end else begin
                slv_miso = slv_sh[7];
                slv_sh   = {slv_sh[6:0], 1'b0};
            end
        end
    end

    // miso source: constant, loopback of mosi, or the bitrev slave.
    always_comb begin
        case (miso_mode)
            2'd0:    miso = miso_const;
            2'd1:    miso = mosi_m;
            2'd2:    miso = slv_miso;
            default: miso = 1'b1;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          g_rise, g_ss_low, g_rv_n, g_rv_cnt;
    logic [31:0] g_mosi;
    logic [15:0] g_rx;
    logic        g_rdy_rv, g_rdy_after, g_ss1, g_busy1, g_done;

    // One transaction on instance s. n counts cycles after the accept cycle.
    // intr_n > 0 pulses a conflicting request at cycle intr_n; rst_rise > 0
    // asserts reset right after that rising sck edge and checks the pins.
    task automatic do_xfer(input logic [1:0] s, input logic [4:0] len,
                           input logic [15:0] tx, input logic lsb,
                           input int intr_n, input int rst_rise);
        logic prev;
        int   w;
        sel = s;
        w = 0;
        @(negedge clk);
        while (!rdy_m && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!rdy_m) check_eq("ready_wait", 32'(rdy_m), 32'd1);
        req_len_tb = len; req_tx_tb = tx; req_lsb_tb = lsb; req_valid_tb = 1'b1;
        @(negedge clk);
        req_valid_tb = 1'b0;
        g_rise = 0; g_ss_low = 0; g_rv_n = 0; g_rv_cnt = 0; g_mosi = 32'd0;
        g_rx = 16'd0; g_rdy_rv = 1'b1; g_rdy_after = 1'b0; g_ss1 = 1'b1;
        g_busy1 = 1'b0; g_done = 1'b0;
        prev = 1'b0;
        for (int n = 1; n <= 700; n++) begin
            if (n == 1) begin
                g_ss1 = ss_m; g_busy1 = busy_m;
            end
            if (sck_m && !prev) begin
                g_rise++;
                g_mosi = {g_mosi[30:0], mosi_m};
            end
            prev = sck_m;
            if (!ss_m) g_ss_low++;
            if (rv_m) begin
                g_rv_cnt++;
                if (g_rv_n == 0) begin
                    g_rv_n = n; g_rdy_rv = rdy_m; g_rx = rx_m;
                end
            end
            if (g_rv_n != 0 && n == g_rv_n + 1) begin
                g_rdy_after = rdy_m; g_done = 1'b1;
                break;
            end
            if (intr_n > 0 && n == intr_n) begin
                req_tx_tb = ~tx; req_len_tb = 5'd16; req_valid_tb = 1'b1;
            end else begin
                req_valid_tb = 1'b0;
            end
            if (rst_rise > 0 && g_rise == rst_rise) begin
                reset = 1'b1;
                #1;
                check_eq("rst_ss",    32'(ss_m),   32'd1);
                check_eq("rst_sck",   32'(sck_m),  32'd0);
                check_eq("rst_mosi",  32'(mosi_m), 32'd1);
                check_eq("rst_rv",    32'(rv_m),   32'd0);
                check_eq("rst_rx",    32'(rx_m),   32'd0);
                check_eq("rst_busy",  32'(busy_m), 32'd0);
                g_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!g_done) check_eq("timeout", 32'd0, 32'd1);
    endtask

    int   rv_seen, gap, min_gap;
    logic in_gap, seen_low;

    initial begin
        reset = 1'b1; sel = 2'd0; req_valid_tb = 1'b0; req_len_tb = 5'd8;
        req_tx_tb = 16'h0000; req_lsb_tb = 1'b0; miso_mode = 2'd0; miso_const = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_sck",   32'(sck_m),  32'd0);
        check_eq("reset_ss",    32'(ss_m),   32'd1);
        check_eq("reset_mosi",  32'(mosi_m), 32'd1);
        check_eq("reset_ready", 32'(rdy_m),  32'd1);
        check_eq("reset_rv",    32'(rv_m),   32'd0);
        check_eq("reset_rx",    32'(rx_m),   32'd0);
        check_eq("reset_busy",  32'(busy_m), 32'd0);

        // D=4, N=8, 0x3C MSB-first, miso held at 1.
        do_xfer(2'd0, 5'd8, 16'h003C, 1'b0, 0, 0);
        check_eq("m8_mosi",     g_mosi,             32'h3C);
        check_eq("m8_rise",     32'(g_rise),        32'd8);
        check_eq("m8_ss_low",   32'(g_ss_low),      32'd68);
        check_eq("m8_rv_time",  32'(g_rv_n),        32'd69);
        check_eq("m8_rv_count", 32'(g_rv_cnt),      32'd1);
        check_eq("m8_rx",       32'(g_rx),          32'h00FF);
        check_eq("m8_ss_first", 32'(g_ss1),         32'd0);
        check_eq("m8_busy",     32'(g_busy1),       32'd1);
        check_eq("m8_rdy_rv",   32'(g_rdy_rv),      32'd0);
        check_eq("m8_rdy_aft",  32'(g_rdy_after),   32'd1);

        // D=2, N=16 against the bitrev slave.
        miso_mode = 2'd2;
        do_xfer(2'd1, 5'd16, 16'hA500, 1'b0, 0, 0);
        check_eq("brev_rx",   32'(g_rx),   32'hFFA5);
        check_eq("brev_rise", 32'(g_rise), 32'd16);
        check_eq("brev_time", 32'(g_rv_n), 32'd67);

        // LSB-first with mosi looped back to miso.
        miso_mode = 2'd1;
        do_xfer(2'd0, 5'd4, 16'h0001, 1'b1, 0, 0);
        check_eq("lsb4_mosi", g_mosi,           32'h8);
        check_eq("lsb4_rx",   32'(g_rx),        32'h0001);
        check_eq("lsb4_time", 32'(g_rv_n),      32'd37);
        do_xfer(2'd0, 5'd8, 16'h00B2, 1'b1, 0, 0);
        check_eq("lsb8_mosi", g_mosi,           32'h4D);
        check_eq("lsb8_rx",   32'(g_rx),        32'h00B2);

        // Length edge cases on D=1.
        do_xfer(2'd2, 5'd0, 16'h1234, 1'b0, 0, 0);
        check_eq("len0_rise", 32'(g_rise),      32'd16);
        check_eq("len0_rx",   32'(g_rx),        32'h1234);
        check_eq("len0_time", 32'(g_rv_n),      32'd34);
        do_xfer(2'd2, 5'd20, 16'hBEEF, 1'b0, 0, 0);
        check_eq("len20_rise", 32'(g_rise),     32'd16);
        check_eq("len20_rx",   32'(g_rx),       32'hBEEF);
        miso_mode = 2'd0; miso_const = 1'b1;
        do_xfer(2'd2, 5'd1, 16'h0000, 1'b0, 0, 0);
        check_eq("len1_rise", 32'(g_rise),      32'd1);
        check_eq("len1_rx",   32'(g_rx),        32'h0001);
        check_eq("len1_time", 32'(g_rv_n),      32'd4);
        miso_mode = 2'd1;
        do_xfer(2'd2, 5'd8, 16'h00C3, 1'b0, 0, 0);
        check_eq("d1_rx",   32'(g_rx),   32'h00C3);
        check_eq("d1_time", 32'(g_rv_n), 32'd18);

        // Reset after the 5th rising edge, then a normal transaction.
        do_xfer(2'd0, 5'd8, 16'h003C, 1'b0, 0, 5);
        @(negedge clk);
        reset = 1'b0;
        rv_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv_m) rv_seen++;
        end
        check_eq("rst_no_rv", 32'(rv_seen), 32'd0);
        do_xfer(2'd0, 5'd8, 16'h0096, 1'b0, 0, 0);
        check_eq("post_rst_rx",   32'(g_rx),     32'h0096);
        check_eq("post_rst_time", 32'(g_rv_n),   32'd69);

        // Conflicting request during the transfer is ignored.
        do_xfer(2'd0, 5'd8, 16'h005A, 1'b0, 10, 0);
        check_eq("busy_req_rx",   32'(g_rx),     32'h005A);
        check_eq("busy_req_rise", 32'(g_rise),   32'd8);
        check_eq("busy_req_time", 32'(g_rv_n),   32'd69);
        check_eq("busy_req_rvc",  32'(g_rv_cnt), 32'd1);

        // D=1 back-to-back with req_valid held high: ss must reopen between.
        sel = 2'd2; req_len_tb = 5'd2; req_tx_tb = 16'h0003; req_lsb_tb = 1'b0;
        req_valid_tb = 1'b1;
        rv_seen = 0; gap = 0; min_gap = 1000; in_gap = 1'b0; seen_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rv_m) rv_seen++;
            if (!ss_m) begin
                if (in_gap) begin
                    if (gap < min_gap) min_gap = gap;
                    in_gap = 1'b0;
                end
                seen_low = 1'b1;
            end else if (seen_low) begin
                if (!in_gap) begin
                    in_gap = 1'b1; gap = 0;
                end
                gap++;
            end
        end
        req_valid_tb = 1'b0;
        check_eq("b2b_gap",   32'((min_gap >= 1) && (min_gap < 1000)), 32'd1);
        check_eq("b2b_count", 32'(rv_seen >= 3), 32'd1);
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master.md
# spi_master

Byte/word-oriented SPI master that drives `sck`/`ss`/`mosi` toward SPI slave peripherals such as the bitrev device and samples `miso` back. It sits between the core-side peripheral bus adapter and the SPI pins. It accepts one transaction of 1–16 bits through a valid/ready request port, serialises the data in SPI mode 0 (CPOL=0), and returns the captured receive word on a one-cycle response strobe.

## Interface
- `DIV`, 4: sck half-period in `clk` cycles; legal values are ≥1.
- `MAX_LEN`, 16: maximum bits per transaction; also the width of `req_tx` and `resp_rx`.
- `clk`  in  1  system clock; all logic is in this domain.
- `reset`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  transaction request.
- `req_ready`  out  1  master idle and able to accept a request.
- `req_len`  in  5  bit count; 0 or >16 is treated as 16.
- `req_tx`  in  16  transmit word, right-aligned (bits [N-1:0] are used).
- `req_lsb_first`  in  1  1: send/receive bit 0 first; 0: send/receive bit N-1 first.
- `resp_valid`  out  1  one-cycle pulse when `resp_rx` is valid.
- `resp_rx`  out  16  received word, right-aligned; bits above N-1 are 0.
- `busy`  out  1  transaction in progress.
- `sck`  out  1  SPI clock, idles low.
- `ss`  out  1  slave select, active-low, idles high.
- `mosi`  out  1  serial out, idles high.
- `miso`  in  1  serial in. Treated as synchronous to `clk`; there is no synchronizer.

## Operation
- FSM states: IDLE → SETUP → XFER → HOLD → IDLE.
- **IDLE:** `req_ready`=1. When `req_valid&&req_ready`, latch len N, tx, order; clear the rx shift register; go to SETUP.
- **SETUP:** `ss`=0, `mosi`=first bit, `sck`=0. Lasts DIV cycles, then go to XFER.
- **XFER:**
  - Half-period divider `cnt` counts 0..DIV-1; the wrap is a tick; `sck` toggles on each tick.
  - On a rising tick (sck 0→1), `mosi` is held (slave samples here).
  - On a falling tick (sck 1→0):
    - Sample `miso` (value present in the cycle before sck drops) into the rx shift register.
    - Increment the bit counter.
    - If the count equals N, go to HOLD. Otherwise present the next bit on `mosi`.
- **HOLD:** `sck`=0 and `mosi` holds its last bit for DIV cycles. Then `ss`=1, `mosi`=1, `resp_valid`=1 for one cycle, `resp_rx` is updated, and the FSM returns to IDLE.
- **MSB-first:** tx bits are sent in order N-1..0. Each sample does `rx={rx[14:0],miso}`, giving a right-aligned result.
- **LSB-first:** tx bits are sent in order 0..N-1. The k-th sample (k=0..N-1) is written to `rx[k]`.
- `resp_rx` holds its value until the next response. It is not cleared by a new request.
- `busy`=1 from SETUP through HOLD inclusive. `req_ready`=!busy, except that it is 0 in the `resp_valid` cycle.
- Requests while busy are ignored; `req_*` is sampled only at acceptance.
- **Async reset mid-transaction:** immediately drives `ss`=1, `sck`=0, `mosi`=1, all counters to 0, and the FSM to IDLE. No `resp_valid` is issued; `resp_rx` is cleared to 0.
- **DIV=1:** sck runs at clk/2; all rules above are unchanged.

## Timing
- Reset values: `sck`=0, `ss`=1, `mosi`=1, `req_ready`=1, `resp_valid`=0, `resp_rx`=0, `busy`=0.
- For a request accepted at clk edge T, with N bits and D=DIV:
  - `ss` falls, `mosi`=bit1, and `busy`=1 at T+1.
  - Rising sck edge k (k=1..N) at T+1+(2k-1)·D.
  - Falling edge k at T+1+2k·D; `miso` is sampled there and `mosi` changes to bit k+1.
  - `ss` rises and `resp_valid` pulses at T+1+(2N+1)·D.
  - `req_ready` returns at T+2+(2N+1)·D.
- All outputs are registered; `sck`, `ss`, and `mosi` are glitch-free.
- Back-to-back requests: `ss` stays high for ≥1 clk between transactions.

## Test plan
- **Reset values:** after reset, check every output's reset value. Assert `req_valid` with N=8, D=4, tx=0x3C, MSB-first; `mosi` must show 0,0,1,1,1,1,0,0 at the 8 rising edges, `ss` must be low for exactly 2·8·4+4 cycles, and `resp_valid` must fire once at T+69.
- **Loopback to the bitrev model:** the slave samples on rise, drives 1 during its receive byte, then returns the received byte MSB-first with `miso` updated on rise. Use N=16, tx=0xA500, MSB-first, D=2; require `resp_rx`=0xFFA5.
- **LSB-first:** tx=0x0001, N=4, with `miso` tied to `mosi` externally. Require `mosi` sequence 1,0,0,0 and `resp_rx`=0x0001.
- **Length edge cases:** `req_len`=0 and `req_len`=20 must both produce exactly 16 sck pulses. `req_len`=1 with `miso`=1 must give `resp_rx`=0x0001 after a single sck pulse.
- **Reset mid-transaction:** assert `reset` after the 5th rising edge. `ss`=1 and `sck`=0 are required in the same cycle, with no `resp_valid`. A following N=8 transaction must complete normally.
- **Request while busy:** pulse `req_valid` with different data during XFER; it must be ignored and the original `resp_rx` is returned. D=1 back-to-back requests must show a ≥1-cycle `ss` gap.
